// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipe: issues loads/stores on the data bus, aligns and
// extends load data, and registers the MEM/WB slot. Stalls upstream while an access is pending.
module mem_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CSR_OP_W   = 2,
    parameter int unsigned CSR_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ex2mem_valid,
    input  logic                  ex2mem_reg_wen,
    input  logic [4:0]            ex2mem_reg_waddr,
    input  logic [XLEN-1:0]       ex2mem_alu_out,
    input  logic                  ex2mem_mem_rd,
    input  logic                  ex2mem_mem_wr,
    input  logic [1:0]            ex2mem_mem_size,
    input  logic                  ex2mem_mem_unsigned,
    input  logic [XLEN-1:0]       ex2mem_mem_wdata,
    input  logic                  ex2mem_csr_rd,
    input  logic [CSR_OP_W-1:0]   ex2mem_csr_wr_op,
    input  logic [XLEN-1:0]       ex2mem_csr_wdata,
    input  logic [CSR_ADDR_W-1:0] ex2mem_csr_addr,
    input  logic                  ex2mem_sel_csr,
    input  logic                  ex2mem_ill_instr,

    output logic                  mem_stall,

    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [XLEN-1:0]       dbus_addr,
    output logic [XLEN-1:0]       dbus_wdata,
    output logic [3:0]            dbus_byteen,
    input  logic                  dbus_ready,
    input  logic                  dbus_rvalid,
    input  logic [XLEN-1:0]       dbus_rdata,

    output logic                  mem2wb_reg_wen,
    output logic [4:0]            mem2wb_reg_waddr,
    output logic [XLEN-1:0]       mem2wb_reg_wdata,
    output logic                  mem2wb_csr_rd,
    output logic [CSR_OP_W-1:0]   mem2wb_csr_wr_op,
    output logic [XLEN-1:0]       mem2wb_csr_wdata,
    output logic [CSR_ADDR_W-1:0] mem2wb_csr_addr,
    output logic                  mem2wb_sel_csr,
    output logic                  mem2wb_ill_instr,
    output logic                  mem2wb_misaligned
);

    localparam int unsigned SZ_BYTE = 0;
    localparam int unsigned SZ_HALF = 1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Load formatting info captured when the request is accepted
    logic [1:0] off_q, off_d;
    logic [1:0] size_q, size_d;
    logic       uns_q, uns_d;

    logic                  reg_wen_q, reg_wen_d;
    logic [4:0]            reg_waddr_q, reg_waddr_d;
    logic [XLEN-1:0]       reg_wdata_q, reg_wdata_d;
    logic                  csr_rd_q, csr_rd_d;
    logic [CSR_OP_W-1:0]   csr_wr_op_q, csr_wr_op_d;
    logic [XLEN-1:0]       csr_wdata_q, csr_wdata_d;
    logic [CSR_ADDR_W-1:0] csr_addr_q, csr_addr_d;
    logic                  sel_csr_q, sel_csr_d;
    logic                  ill_instr_q, ill_instr_d;
    logic                  misaligned_q, misaligned_d;

    logic [1:0]      off_c;
    logic            is_mem_c;
    logic            aligned_c;
    logic            access_c;
    logic            misaligned_c;
    logic [XLEN-1:0] store_wdata_c;
    logic [3:0]      store_be_c;
    logic [XLEN-1:0] shifted_c;
    logic [XLEN-1:0] load_data_c;
    logic            retire_c;
    logic            ret_mis_c;
    logic [XLEN-1:0] ret_data_c;

    assign off_c        = ex2mem_alu_out[1:0];
    assign is_mem_c     = ex2mem_mem_rd | ex2mem_mem_wr;
    assign access_c     = ex2mem_valid & is_mem_c & aligned_c;
    assign misaligned_c = ex2mem_valid & is_mem_c & ~aligned_c;

    always_comb begin
        aligned_c = 1'b0;
        case (ex2mem_mem_size)
            2'(SZ_BYTE): aligned_c = 1'b1;
            2'(SZ_HALF): aligned_c = ~off_c[0];
            default:     aligned_c = (off_c == 2'b00);
        endcase
    end

    // Store data replicated across lanes; byte enables pick the addressed lane(s)
    always_comb begin
        store_wdata_c = ex2mem_mem_wdata;
        store_be_c    = 4'hF;
        case (ex2mem_mem_size)
            2'(SZ_BYTE): begin
                store_wdata_c = {4{ex2mem_mem_wdata[7:0]}};
                store_be_c    = 4'b0001 << off_c;
            end
            2'(SZ_HALF): begin
                store_wdata_c = {2{ex2mem_mem_wdata[15:0]}};
                store_be_c    = 4'b0011 << off_c;
            end
            default: begin
                store_wdata_c = ex2mem_mem_wdata;
                store_be_c    = 4'hF;
            end
        endcase
    end

    assign shifted_c = dbus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data_c = shifted_c;
        case (size_q)
            2'(SZ_BYTE): load_data_c = uns_q ? XLEN'(shifted_c[7:0])
                                             : {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
            2'(SZ_HALF): load_data_c = uns_q ? XLEN'(shifted_c[15:0])
                                             : {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
            default:     load_data_c = shifted_c;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    // Bus FSM: request straight from EX/MEM in IDLE, then wait for read data
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        dbus_req    = 1'b0;
        dbus_we     = 1'b0;
        dbus_addr   = {ex2mem_alu_out[XLEN-1:2], 2'b00};
        dbus_wdata  = store_wdata_c;
        dbus_byteen = store_be_c;
        mem_stall   = 1'b0;
        retire_c    = 1'b0;
        ret_mis_c   = 1'b0;
        ret_data_c  = ex2mem_alu_out;

        case (state_q)
            IDLE: begin
                if (access_c) begin
                    dbus_req = 1'b1;
                    dbus_we  = ~ex2mem_mem_rd;
                    if (dbus_ready) begin
                        if (ex2mem_mem_rd) begin
                            state_d   = WAIT_RSP;
                            mem_stall = 1'b1;
                            off_d     = off_c;
                            size_d    = ex2mem_mem_size;
                            uns_d     = ex2mem_mem_unsigned;
                        end else begin
                            retire_c = 1'b1;
                        end
                    end else begin
                        mem_stall = 1'b1;
                    end
                end else if (misaligned_c) begin
                    retire_c  = 1'b1;
                    ret_mis_c = 1'b1;
                end else if (ex2mem_valid) begin
                    retire_c = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (dbus_rvalid) begin
                    state_d    = IDLE;
                    retire_c   = 1'b1;
                    ret_data_c = load_data_c;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Non-retiring cycles write a bubble so WB never repeats side effects
    always_comb begin
        reg_wen_d    = retire_c & ex2mem_reg_wen & ~ret_mis_c;
        reg_waddr_d  = ex2mem_reg_waddr;
        reg_wdata_d  = ret_data_c;
        csr_rd_d     = retire_c & ex2mem_csr_rd;
        csr_wr_op_d  = retire_c ? ex2mem_csr_wr_op : '0;
        csr_wdata_d  = ex2mem_csr_wdata;
        csr_addr_d   = ex2mem_csr_addr;
        sel_csr_d    = ex2mem_sel_csr;
        ill_instr_d  = retire_c & ex2mem_ill_instr;
        misaligned_d = ret_mis_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wen_q    <= 1'b0;
            reg_waddr_q  <= '0;
            reg_wdata_q  <= '0;
            csr_rd_q     <= 1'b0;
            csr_wr_op_q  <= '0;
            csr_wdata_q  <= '0;
            csr_addr_q   <= '0;
            sel_csr_q    <= 1'b0;
            ill_instr_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            reg_wen_q    <= reg_wen_d;
            reg_waddr_q  <= reg_waddr_d;
            reg_wdata_q  <= reg_wdata_d;
            csr_rd_q     <= csr_rd_d;
            csr_wr_op_q  <= csr_wr_op_d;
            csr_wdata_q  <= csr_wdata_d;
            csr_addr_q   <= csr_addr_d;
            sel_csr_q    <= sel_csr_d;
            ill_instr_q  <= ill_instr_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign mem2wb_reg_wen    = reg_wen_q;
    assign mem2wb_reg_waddr  = reg_waddr_q;
    assign mem2wb_reg_wdata  = reg_wdata_q;
    assign mem2wb_csr_rd     = csr_rd_q;
    assign mem2wb_csr_wr_op  = csr_wr_op_q;
    assign mem2wb_csr_wdata  = csr_wdata_q;
    assign mem2wb_csr_addr   = csr_addr_q;
    assign mem2wb_sel_csr    = sel_csr_q;
    assign mem2wb_ill_instr  = ill_instr_q;
    assign mem2wb_misaligned = misaligned_q;

endmodule
